// File: rtl/eth_rx_mac.sv
// rtl/eth_rx_mac.sv - Ethernet RX MAC: frame delimiting, FCS check/strip, EOF/error marking, counters (optional ETH_RX_ADDR_FILTER_EN)
module eth_rx_mac #(
  parameter int          MIN_FRAME = 64,
  parameter int          MAX_FRAME = 1518,
  parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_eof,
  output logic        out_err,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic [4:0][7:0]   dl_q, dl_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_eof_q, out_eof_d;
  logic              out_err_q, out_err_d;
  logic [15:0]       ok_q, ok_d;
  logic [15:0]       err_q, err_d;

  logic [10:0]       cnt_inc;
  logic [31:0]       crc_next;
  logic              frame_bad;
  logic              da_ok;

  // Reflected CRC-32, one byte per call, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cnt_inc   = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign crc_next  = crc_byte(crc_q, in_data);
  assign frame_bad = (crc_q != CRC_RESIDUE) || (cnt_q < MIN_LEN) || (cnt_q > MAX_LEN);

`ifdef ETH_RX_ADDR_FILTER_EN
  // DA is bytes 1..5 still in the delay line (oldest first) plus the 6th on the input
  logic [47:0] da;
  assign da    = {dl_q[4], dl_q[3], dl_q[2], dl_q[1], dl_q[0], in_data};
  assign da_ok = (da == MAC_ADDR) || (da == 48'hFFFF_FFFF_FFFF);
`else
  logic unused_mac_addr;
  assign unused_mac_addr = ^MAC_ADDR;
  assign da_ok           = 1'b1;
`endif

  // Next-state, delay line, CRC, output and counter logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    dl_d        = dl_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_eof_d   = 1'b0;
    out_err_d   = 1'b0;
    ok_d        = ok_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_FILL;
          cnt_d   = 11'd1;
          crc_d   = crc_byte(CRC_INIT, in_data);
          dl_d    = {32'h0, in_data};
        end
      end

      S_FILL: begin
        if (in_valid) begin
          cnt_d = cnt_inc;
          crc_d = crc_next;
          dl_d  = {dl_q[3:0], in_data};
          if (cnt_q == 11'd4) begin
            state_d = S_STREAM;
          end
        end else begin
          // Runt: nothing was emitted, so only the error counter records it
          err_d   = sat_inc(err_q);
          cnt_d   = '0;
          dl_d    = '0;
          state_d = S_IDLE;
        end
      end

      S_STREAM: begin
        if (in_valid) begin
          if (cnt_q == 11'd5 && !da_ok) begin
            state_d = S_DROP;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = dl_q[4];
            cnt_d       = cnt_inc;
            crc_d       = crc_next;
            dl_d        = {dl_q[3:0], in_data};
          end
        end else begin
          // Oldest entry is the last payload byte; the other four are the FCS
          out_valid_d = 1'b1;
          out_data_d  = dl_q[4];
          out_eof_d   = 1'b1;
          out_err_d   = frame_bad;
          if (frame_bad) begin
            err_d = sat_inc(err_q);
          end else begin
            ok_d = sat_inc(ok_q);
          end
          cnt_d   = '0;
          dl_d    = '0;
          state_d = S_IDLE;
        end
      end

      S_DROP: begin
        if (!in_valid) begin
          cnt_d   = '0;
          dl_d    = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      crc_q       <= CRC_INIT;
      dl_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      ok_q        <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      dl_q        <= dl_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_eof    = out_eof_q;
  assign out_err    = out_err_q;
  assign frames_ok  = ok_q;
  assign frames_err = err_q;

endmodule

// File: doc/eth_rx_mac.md
# eth_rx_mac

Receive-side Ethernet MAC that consumes the decoded byte stream from the SGMII PCS RX channel (`valid_out`/`data_out`) and delivers frame bytes to the user side. It tracks frame boundaries from valid gaps, checks the CRC-32 FCS and frame length, strips the FCS, and marks the last byte with EOF and an error flag. Saturating good/bad frame counters are provided for status registers.

## Interface
- `MIN_FRAME`, 64: minimum legal frame length in bytes, DA through FCS.
- `MAX_FRAME`, 1518: maximum legal frame length in bytes, DA through FCS.
- `MAC_ADDR`, 48'h02_00_00_00_00_01: station address, first transmitted byte in [47:40]. Used only with the filter enabled.
- `clk`  in  1  125 MHz PCS clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte strobe from PCS. A frame is one contiguous run of high cycles (SFD already stripped). Frames are separated by ≥1 low cycle.
- `in_data`  in  8  frame byte, sampled when `in_valid`=1.
- `out_valid`  out  1  output byte strobe. There is no backpressure.
- `out_data`  out  8  payload byte (DA … last data byte; FCS never output).
- `out_eof`  out  1  high with the last byte of a frame.
- `out_err`  out  1  meaningful only with `out_eof`: 1 = CRC mismatch or length out of range.
- `frames_ok`  out  16  count of frames delivered with `out_err`=0; saturates at 16'hFFFF.
- `frames_err`  out  16  count of frames delivered with `out_err`=1, plus dropped runts; saturates.

## Operation
- **Delay line:** a 5-entry byte shift register with a byte count `cnt` (11 bits, saturates at 2047).
  - Each accepted byte shifts in.
  - Once `cnt` ≥ 5 before the shift, the oldest entry is emitted.
  - Holding 5 bytes means the final payload byte is still buffered when `in_valid` falls, so it can carry EOF.
- **CRC:** reflected CRC-32 (poly 0xEDB88320, LSB-first), init 32'hFFFFFFFF at frame start. It updates on every accepted byte, including the FCS. The frame is good when the register equals the residue 32'hDEBB20E3 after the last byte.
- **States:**
  - IDLE: `in_valid`=1 → FILL, with `cnt`=1 and CRC seeded with that byte.
  - FILL (`cnt` < 5): on `in_valid`=0, the frame is a runt. No output is produced, `frames_err` increments, and the block returns to IDLE.
  - FILL, 5th byte accepted → STREAM.
  - STREAM: emit one byte per accepted byte. On the first cycle with `in_valid`=0, flush the oldest entry with `out_eof`=1, update the counters, clear the delay line, and go to IDLE.
  - DROP (filter only): accept and discard bytes until `in_valid`=0, then go to IDLE. No output and no counter change.
- **Error condition:** `out_err` = (CRC ≠ residue) | (`cnt` < `MIN_FRAME`) | (`cnt` > `MAX_FRAME`).
- **Oversize frames:** bytes continue streaming past `MAX_FRAME`; the error is reported only at EOF.
- **Back-to-back frames:** if `in_valid` reasserts on the cycle after the flush cycle, the new frame starts normally from IDLE.
- **Reset:** `reset_n`=0 at any point, including mid-frame, gives:
  - state IDLE, `cnt`=0;
  - `out_valid`=`out_eof`=`out_err`=0, `out_data`=0;
  - both counters 0.
  
  The partial frame is discarded without any EOF.

## Timing
- All outputs are registered.
- **Streaming latency:** the byte accepted at edge *t* is emitted when byte *n*+5 is accepted; it appears on `out_data` in the cycle after that edge.
- **EOF:** first cycle with `in_valid`=0 is *e*. In cycle *e*+1: `out_valid`=`out_eof`=1, `out_err` valid, and the counters already updated.
- `out_valid` is high for exactly `cnt`−4 cycles per delivered frame. These cycles are contiguous except at EOF, which follows the last streaming cycle by one cycle.

## Configuration
- **`ETH_RX_ADDR_FILTER_EN` defined:**
  - The destination address is compared in the cycle the 6th byte is accepted, using bytes 1–5 from the delay line plus `in_data`.
  - The frame passes if the address equals `MAC_ADDR` or 48'hFFFFFFFFFFFF.
  - Otherwise the block enters DROP. Byte 1 is not yet emitted at that point, so the frame produces no output at all.
  - Frames shorter than 6 bytes follow the runt/short rules unchanged.
- **Undefined:** no filtering; all frames are delivered and DROP is unreachable.

## Test plan
- **Good frame:** 64-byte frame (60 data bytes + correct FCS) → 60 `out_valid` cycles, last with `out_eof`=1 and `out_err`=0; `frames_ok`=1; first output one cycle after byte 6 is accepted.
- **Bad CRC:** same frame with FCS byte 0 XOR 8'h01 → 60 bytes output, `out_eof`=1, `out_err`=1; `frames_err`=1.
- **Runt / short:**
  - 3-byte burst → no `out_valid`; `frames_err` increments.
  - 20-byte frame with correct CRC → 16 bytes output, `out_err`=1.
- **Oversize:** 1519-byte frame with correct CRC → 1515 bytes output, `out_err`=1.
- **Back-to-back / counters:** two 64-byte good frames separated by one idle cycle → both delivered intact, `frames_ok`=2. Preload a counter at 16'hFFFF → it stays at 16'hFFFF.
- **Reset / filter:**
  - `reset_n`=0 at byte 30 → outputs and counters go to 0; the next frame is delivered correctly.
  - With `ETH_RX_ADDR_FILTER_EN`: DA ≠ `MAC_ADDR` and not broadcast → zero output; broadcast DA → delivered.
